// File: rtl/line_buffer_rr.sv
// Round-robin row line buffer: captures de_in-qualified raster rows into NUM_LINES
// row memories and presents all stored rows in parallel, lane 0 being the oldest.
module line_buffer_rr #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          start_frame,
  input  logic                          de_in,
  input  logic [DATA_W-1:0]             din,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [NUM_LINES*DATA_W-1:0]   rd_q,
  output logic                          rd_valid,
  output logic [$clog2(NUM_LINES):0]    lines_avail,
  output logic                          row_done,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int unsigned BANK_W = $clog2(NUM_LINES);
  localparam int unsigned LA_W   = BANK_W + 1;
  localparam int unsigned COL_W  = ADDR_W + 1;
  localparam int unsigned ROW_W  = $clog2(IMG_H) + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0]           mem [NUM_LINES][DEPTH];
  logic [DATA_W-1:0]           rd_word [NUM_LINES];
  logic [COL_W-1:0]            wr_col;
  logic [BANK_W-1:0]           wr_bank;
  logic [ROW_W-1:0]            row_cnt;
  logic                        de_q;
  logic                        rd_pend;
  logic [BANK_W-1:0]           rd_bank;

  logic                        col_ok_c;
  logic                        wr_c;
  logic [BANK_W-1:0]           wr_bank_c;
  logic [ADDR_W-1:0]           wr_addr_c;
  logic                        row_end_c;
  logic                        last_row_c;
  logic [NUM_LINES*DATA_W-1:0] rot_c;

  // A start_frame pixel lands in bank 0, column 0 regardless of the current pointers
  always_comb begin
    col_ok_c   = wr_col < COL_W'(IMG_W);
    wr_c       = de_in && (start_frame || col_ok_c);
    wr_bank_c  = start_frame ? '0 : wr_bank;
    wr_addr_c  = start_frame ? '0 : ADDR_W'(wr_col);
    row_end_c  = de_q && !de_in;
    last_row_c = row_cnt == ROW_W'(IMG_H - 1);
  end

  // Lane k reads bank (wr_bank at request + k), so the bank being overwritten is lane 0
  always_comb begin
    rot_c = '0;
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      rot_c[k*DATA_W +: DATA_W] = rd_word[BANK_W'(rd_bank + BANK_W'(k))];
    end
  end

  // Row memories: no reset, read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[wr_bank_c][wr_addr_c] <= din;
    end
    if (rd_en) begin
      for (int unsigned k = 0; k < NUM_LINES; k++) begin
        rd_word[k] <= mem[k][rd_addr];
      end
    end
  end

  // Write pointer, row/frame tracking and overrun flag
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_col      <= '0;
      wr_bank     <= '0;
      row_cnt     <= '0;
      lines_avail <= '0;
      de_q        <= 1'b0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      de_q       <= de_in;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      if (start_frame) begin
        wr_col      <= de_in ? COL_W'(1) : '0;
        wr_bank     <= '0;
        row_cnt     <= '0;
        lines_avail <= '0;
        overrun     <= 1'b0;
      end else if (row_end_c) begin
        row_done <= 1'b1;
        wr_col   <= '0;
        wr_bank  <= wr_bank + BANK_W'(1);
        if (last_row_c) begin
          frame_done  <= 1'b1;
          row_cnt     <= '0;
          lines_avail <= '0;
        end else begin
          row_cnt <= row_cnt + ROW_W'(1);
          if (lines_avail != LA_W'(NUM_LINES)) begin
            lines_avail <= lines_avail + LA_W'(1);
          end
        end
      end else if (de_in) begin
        if (col_ok_c) begin
          wr_col <= wr_col + COL_W'(1);
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Two-stage read pipeline: bank read, then lane rotation into rd_q
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rd_pend  <= 1'b0;
      rd_bank  <= '0;
      rd_valid <= 1'b0;
      rd_q     <= '0;
    end else begin
      rd_pend <= rd_en;
      rd_bank <= wr_bank;
      if (start_frame) begin
        rd_valid <= 1'b0;
        rd_q     <= '0;
      end else begin
        rd_valid <= rd_pend;
        if (rd_pend) begin
          rd_q <= rot_c;
        end
      end
    end
  end

endmodule
